// File: rtl/usb_phy_rx_pkg.sv
// Shared types and helpers for the USB FS/LS receive path.
// Provides the receive sequencer state encoding, the error codes reported to
// the link layer, the SYNC/PID field width and a bit-reversal helper used to
// turn MSB-first deserializer bytes into USB LSB-first bytes.
package usb_phy_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        ACTIVE,
        EOP,
        DRAIN
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_STUFF  = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_BABBLE = 2'd3
    } rx_err_e;

    // Width of the SYNC field and of every byte; payload framing repeats on it.
    localparam int SYNC_PID_BITS = 8;

    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_sync_hunter.sv
// SYNC detector for the receive sequencer.
// Counts consecutive decoded zeros (saturating at MIN_SYNC_ZEROS) while
// hunting and flags the terminating 1 once enough zeros were seen. Starting
// later than the first SYNC bit is tolerated because only the tail matters.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_hunt          counter runs only while high, otherwise held at zero
//   i_bit           decoded bit
//   i_bit_valid     bit / SE0 qualifier
//   i_se0           line in SE0 this bit time (restarts the zero run)
//   o_hit           combinational sync hit for the current bit
module usb_sync_hunter #(
    parameter int MIN_SYNC_ZEROS = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_hunt,
    input  logic i_bit,
    input  logic i_bit_valid,
    input  logic i_se0,
    output logic o_hit
);

    localparam int RUN_W = $clog2(MIN_SYNC_ZEROS + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_SYNC_ZEROS);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // Zero-run tracking; any 1 or SE0 restarts the run.
    always_comb begin
        run_d = run_q;
        o_hit = 1'b0;
        if (!i_hunt) begin
            run_d = '0;
        end else if (i_bit_valid) begin
            if (i_se0) begin
                run_d = '0;
            end else if (!i_bit) begin
                if (run_q != RUN_MAX) begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                run_d = '0;
                o_hit = (run_q == RUN_MAX);
            end
        end
    end

    // Run counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// FS/LS receive packet sequencer between the NRZI decoder/bit-unstuffer and
// the external 8-bit deserializer. Hunts SYNC, pulses the deserializer sync,
// forwards payload bits, frames the packet on EOP and reports UTMI-style
// RxActive/RxValid/RxData/RxError with stuff, alignment and babble errors.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_enable                  receive enable (low while transmitting)
//   i_bit, i_bit_valid        decoded destuffed bit and its qualifier
//   i_se0                     line in SE0 this bit time
//   i_stuff_err               unstuffer saw seven consecutive ones
//   o_s2p_sync                one-cycle sync pulse to the deserializer
//   o_s2p_data, o_s2p_valid   payload bit to the deserializer
//   i_s2p_data, i_s2p_valid   deserializer byte (first bit in MSB) and strobe
//   o_rx_active               packet in progress
//   o_rx_valid, o_rx_data     received byte in USB LSB-first order
//   o_rx_error                single-cycle error pulse
//   o_rx_err_code             latched error code, cleared on next SYNC
//   o_byte_count              bytes delivered in the current/last packet
module usb_rx_packet_ctrl
    import usb_phy_rx_pkg::*;
#(
    parameter int MIN_SYNC_ZEROS = 4,
    parameter int MAX_BYTES      = 1027,
    parameter int BC_W           = $clog2(MAX_BYTES + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_bit,
    input  logic            i_bit_valid,
    input  logic            i_se0,
    input  logic            i_stuff_err,
    output logic            o_s2p_sync,
    output logic            o_s2p_data,
    output logic            o_s2p_valid,
    input  logic [7:0]      i_s2p_data,
    input  logic            i_s2p_valid,
    output logic            o_rx_active,
    output logic            o_rx_valid,
    output logic [7:0]      o_rx_data,
    output logic            o_rx_error,
    output logic [1:0]      o_rx_err_code,
    output logic [BC_W-1:0] o_byte_count
);

    localparam int PHASE_W = $clog2(SYNC_PID_BITS);
    localparam logic [BC_W-1:0] BYTE_LIMIT = BC_W'(MAX_BYTES);

    rx_state_e          state_q, state_d;
    rx_err_e            err_code_q, err_code_d;
    rx_err_e            err;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BC_W-1:0]    byte_count_q, byte_count_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_active_q, rx_active_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_error_q, rx_error_d;
    logic               se0_seen_q, se0_seen_d;
    logic               eop_j_q, eop_j_d;
    logic               sync_hit;
    logic               byte_in;
    logic               babble;

    usb_sync_hunter #(
        .MIN_SYNC_ZEROS(MIN_SYNC_ZEROS)
    ) u_sync_hunter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_hunt     (i_enable && (state_q == HUNT)),
        .i_bit      (i_bit),
        .i_bit_valid(i_bit_valid),
        .i_se0      (i_se0),
        .o_hit      (sync_hit)
    );

    // The SYNC-terminating 1 is consumed here; only payload bits reach the deserializer.
    assign o_s2p_sync  = sync_hit;
    assign o_s2p_data  = i_bit;
    assign o_s2p_valid = i_enable && (state_q == ACTIVE) && i_bit_valid
                         && !i_se0 && !i_stuff_err;

    // Bytes can still arrive during EOP because the deserializer lags one bit time.
    assign byte_in = i_enable && i_s2p_valid && ((state_q == ACTIVE) || (state_q == EOP));
    assign babble  = byte_in && (byte_count_q == BYTE_LIMIT);

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        err_code_d   = err_code_q;
        byte_count_d = byte_count_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_error_d   = 1'b0;
        se0_seen_d   = se0_seen_q;
        eop_j_d      = eop_j_q;
        err          = ERR_NONE;

        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            if (byte_in && !babble) begin
                rx_valid_d   = 1'b1;
                rx_data_d    = bit_reverse(i_s2p_data);
                byte_count_d = byte_count_q + BC_W'(1);
            end

            case (state_q)
                IDLE: state_d = HUNT;
                HUNT: begin
                    if (sync_hit) begin
                        state_d      = ACTIVE;
                        phase_d      = '0;
                        err_code_d   = ERR_NONE;
                        byte_count_d = '0;
                    end
                end
                ACTIVE: begin
                    if (i_bit_valid) begin
                        if (i_stuff_err) begin
                            err = ERR_STUFF;
                        end else if (i_se0) begin
                            if (phase_q != '0) begin
                                err = ERR_ALIGN;
                            end else begin
                                state_d = EOP;
                            end
                        end else begin
                            phase_d = phase_q + PHASE_W'(1);
                        end
                    end
                end
                EOP: begin
                    // A byte landing together with J holds the exit one more
                    // cycle so the last RxValid comes before RxActive falls.
                    if (eop_j_q || (i_bit_valid && !i_se0)) begin
                        if (byte_in) begin
                            eop_j_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (i_bit_valid) begin
                        if (i_se0) begin
                            se0_seen_d = 1'b1;
                        end else if (se0_seen_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if ((err == ERR_NONE) && babble) begin
                err = ERR_BABBLE;
            end

            // SE0 already on the line when the error hits counts toward the drain exit.
            if (err != ERR_NONE) begin
                state_d    = DRAIN;
                err_code_d = err;
                rx_error_d = 1'b1;
                se0_seen_d = (err != ERR_STUFF)
                             && ((i_bit_valid && i_se0) || (state_q == EOP));
            end
        end

        if (state_d != EOP) begin
            eop_j_d = 1'b0;
        end
        if (state_d != DRAIN) begin
            se0_seen_d = 1'b0;
        end
        rx_active_d = (state_d == ACTIVE) || (state_d == EOP) || (state_d == DRAIN);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            err_code_q   <= ERR_NONE;
            byte_count_q <= '0;
            rx_data_q    <= '0;
            rx_active_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_error_q   <= 1'b0;
            se0_seen_q   <= 1'b0;
            eop_j_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            err_code_q   <= err_code_d;
            byte_count_q <= byte_count_d;
            rx_data_q    <= rx_data_d;
            rx_active_q  <= rx_active_d;
            rx_valid_q   <= rx_valid_d;
            rx_error_q   <= rx_error_d;
            se0_seen_q   <= se0_seen_d;
            eop_j_q      <= eop_j_d;
        end
    end

    assign o_rx_active   = rx_active_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_error    = rx_error_q;
    assign o_rx_err_code = err_code_q;
    assign o_byte_count  = byte_count_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Bench for usb_rx_packet_ctrl with a behavioural MSB-first deserializer.
// Expected bytes and error codes are queued when stimulus is issued and a
// negedge monitor pops and compares them whenever the DUT presents them.
module tb_usb_rx_packet_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       bit_in;
    logic       bit_valid;
    logic       se0_in;
    logic       stuff_in;
    logic       s2p_sync;
    logic       s2p_data;
    logic       s2p_valid;
    logic [7:0] des_byte  = 8'h00;
    logic       des_valid = 1'b0;
    logic       rx_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic [1:0] rx_err_code;
    logic [1:0] byte_count;

    int checks = 0;
    int errors = 0;
    int sync_cnt = 0;
    int fwd_cnt = 0;
    int base_sync;
    int base_fwd;

    logic [7:0] exp_bytes[$];
    logic [1:0] exp_errs[$];

    always #5 clk = ~clk;

    usb_rx_packet_ctrl #(
        .MIN_SYNC_ZEROS(4),
        .MAX_BYTES     (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_bit        (bit_in),
        .i_bit_valid  (bit_valid),
        .i_se0        (se0_in),
        .i_stuff_err  (stuff_in),
        .o_s2p_sync   (s2p_sync),
        .o_s2p_data   (s2p_data),
        .o_s2p_valid  (s2p_valid),
        .i_s2p_data   (des_byte),
        .i_s2p_valid  (des_valid),
        .o_rx_active  (rx_active),
        .o_rx_valid   (rx_valid),
        .o_rx_data    (rx_data),
        .o_rx_error   (rx_error),
        .o_rx_err_code(rx_err_code),
        .o_byte_count (byte_count)
    );

    // Deserializer: first received bit ends up in the MSB, strobe one cycle after the 8th bit.
    logic [7:0] des_sh  = 8'h00;
    logic [2:0] des_cnt = 3'd0;
    always @(posedge clk) begin
        des_valid <= 1'b0;
        if (s2p_sync) begin
            des_cnt <= 3'd0;
        end else if (s2p_valid) begin
            des_sh  <= {des_sh[6:0], s2p_data};
            des_cnt <= des_cnt + 3'd1;
            if (des_cnt == 3'd7) begin
                des_valid <= 1'b1;
                des_byte  <= {des_sh[6:0], s2p_data};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic b, input logic se0, input logic stuff);
        bit_in    = b;
        se0_in    = se0;
        stuff_in  = stuff;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        se0_in    = 1'b0;
        stuff_in  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendSync(input int zeros);
        for (int i = 0; i < zeros; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) applyStimulus(b[i], 1'b0, 1'b0);
    endtask

    task automatic sendEop();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: counts sync/forward strobes and scores every byte and error pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s2p_sync) sync_cnt++;
            if (s2p_valid) fwd_cnt++;
            if (rx_valid) begin
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rx_valid: got data %02h, expected no byte", rx_data);
                end else begin
                    checkOutput("rx_data", {24'h0, rx_data}, {24'h0, exp_bytes.pop_front()});
                end
                checkOutput("active_with_valid", {31'h0, rx_active}, 32'h1);
            end
            if (rx_error) begin
                if (exp_errs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rx_error: got code %0d, expected no error", rx_err_code);
                end else begin
                    checkOutput("rx_err_code_pulse", {30'h0, rx_err_code}, {30'h0, exp_errs.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; bit_in = 1'b0;
        bit_valid = 1'b0; se0_in = 1'b0; stuff_in = 1'b0;
        idleCycles(3);
        checkOutput("rst_active", {31'h0, rx_active}, 32'h0);
        checkOutput("rst_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("rst_error", {31'h0, rx_error}, 32'h0);
        checkOutput("rst_err_code", {30'h0, rx_err_code}, 32'h0);
        checkOutput("rst_count", {30'h0, byte_count}, 32'h0);
        checkOutput("rst_data", {24'h0, rx_data}, 32'h0);
        rst_n = 1'b1;
        enable = 1'b1;
        idleCycles(3);

        $display("[TB] test 1: basic packet 0x69");
        base_sync = sync_cnt;
        sendSync(7);
        checkOutput("t1_active_after_sync", {31'h0, rx_active}, 32'h1);
        exp_bytes.push_back(8'h69);
        sendByte(8'h69);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t1_active_in_eop", {31'h0, rx_active}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_active_after_j", {31'h0, rx_active}, 32'h0);
        checkOutput("t1_sync_pulses", sync_cnt - base_sync, 32'd1);
        checkOutput("t1_count", {30'h0, byte_count}, 32'd1);
        checkOutput("t1_err_code", {30'h0, rx_err_code}, 32'd0);
        checkOutput("t1_bytes_pending", exp_bytes.size(), 32'd0);
        idleCycles(2);

        $display("[TB] test 2: short sync rejected");
        base_sync = sync_cnt;
        sendSync(3);
        checkOutput("t2_active_after_1", {31'h0, rx_active}, 32'h0);
        sendByte(8'h69);
        sendEop();
        checkOutput("t2_sync_pulses", sync_cnt - base_sync, 32'd0);
        checkOutput("t2_active_end", {31'h0, rx_active}, 32'h0);
        idleCycles(2);

        $display("[TB] test 3: misaligned EOP");
        sendSync(6);
        exp_bytes.push_back(8'hA5);
        exp_errs.push_back(2'd2);
        sendByte(8'hA5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_active_in_drain", {31'h0, rx_active}, 32'h1);
        checkOutput("t3_err_code", {30'h0, rx_err_code}, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_active_after_j", {31'h0, rx_active}, 32'h0);
        checkOutput("t3_count", {30'h0, byte_count}, 32'd1);
        checkOutput("t3_pending", exp_bytes.size() + exp_errs.size(), 32'd0);
        idleCycles(2);

        $display("[TB] test 4: stuff error");
        sendSync(5);
        base_fwd = fwd_cnt;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        exp_errs.push_back(2'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(i[0], 1'b0, 1'b0);
        checkOutput("t4_forwarded_bits", fwd_cnt - base_fwd, 32'd5);
        checkOutput("t4_active_held", {31'h0, rx_active}, 32'h1);
        sendEop();
        checkOutput("t4_active_after_j", {31'h0, rx_active}, 32'h0);
        checkOutput("t4_err_code", {30'h0, rx_err_code}, 32'd1);
        checkOutput("t4_count", {30'h0, byte_count}, 32'd0);
        checkOutput("t4_pending", exp_errs.size(), 32'd0);
        idleCycles(2);

        $display("[TB] test 5: babble");
        sendSync(4);
        exp_bytes.push_back(8'h3C);
        exp_bytes.push_back(8'hC3);
        exp_errs.push_back(2'd3);
        sendByte(8'h3C);
        sendByte(8'hC3);
        sendByte(8'h5A);
        sendEop();
        checkOutput("t5_active_after_j", {31'h0, rx_active}, 32'h0);
        checkOutput("t5_count", {30'h0, byte_count}, 32'd2);
        checkOutput("t5_err_code", {30'h0, rx_err_code}, 32'd3);
        checkOutput("t5_pending", exp_bytes.size() + exp_errs.size(), 32'd0);
        idleCycles(2);

        $display("[TB] test 6a: enable dropped mid-packet");
        sendSync(5);
        sendByte(8'h0F);
        checkOutput("t6a_active_before", {31'h0, rx_active}, 32'h1);
        exp_bytes.push_back(8'h0F);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        idleCycles(1);
        checkOutput("t6a_active_after_disable", {31'h0, rx_active}, 32'h0);
        checkOutput("t6a_err_code", {30'h0, rx_err_code}, 32'd0);
        enable = 1'b1;
        idleCycles(3);

        $display("[TB] test 6b: async reset mid-byte");
        sendSync(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6b_active_in_reset", {31'h0, rx_active}, 32'h0);
        checkOutput("t6b_count_in_reset", {30'h0, byte_count}, 32'd0);
        checkOutput("t6b_valid_in_reset", {31'h0, rx_valid}, 32'h0);
        idleCycles(1);
        rst_n = 1'b1;
        idleCycles(3);
        sendSync(6);
        exp_bytes.push_back(8'h81);
        sendByte(8'h81);
        sendEop();
        checkOutput("t6b_active_after_j", {31'h0, rx_active}, 32'h0);
        checkOutput("t6b_count", {30'h0, byte_count}, 32'd1);
        checkOutput("t6b_err_code", {30'h0, rx_err_code}, 32'd0);
        idleCycles(2);
        checkOutput("final_pending", exp_bytes.size() + exp_errs.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
